// File: rtl/bram_arbiter_pkg.sv
// Shared types and constants for the two-port BRAM arbiter.
// Used by bram_arbiter and bram_arb_rr.
package bram_arbiter_pkg;

  localparam int unsigned NUM_REQ    = 2;
  localparam int unsigned RD_LATENCY = 1;
  localparam int unsigned BE_WIDTH   = 4;
  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic {
    ReqM0 = 1'b0,
    ReqM1 = 1'b1
  } req_id_t;

  typedef logic [NUM_REQ-1:0] req_vec_t;

  // Only meaningful for a one-hot or all-zero vector; zero maps to ReqM0.
  function automatic req_id_t onehot_to_id(input req_vec_t oh);
    return oh[1] ? ReqM1 : ReqM0;
  endfunction

endpackage

// File: rtl/bram_arb_rr.sv
// Grant selection for two requesters. With BRAM_ARB_RR_EN defined contention is
// resolved round-robin against last_grant_i, otherwise requester 0 always wins.
module bram_arb_rr
  import bram_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               last_grant_i,
  output logic [NUM_REQ-1:0] grant_o
);

`ifndef BRAM_ARB_RR_EN
  // Fixed priority keeps the arbitration state around but never looks at it.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

  always_comb begin
    grant_o = '0;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11: begin
`ifdef BRAM_ARB_RR_EN
        grant_o = last_grant_i ? 2'b01 : 2'b10;
`else
        grant_o = 2'b01;
`endif
      end
      default: grant_o = '0;
    endcase
  end

endmodule

// File: rtl/bram_arbiter.sv
// Two-requester arbiter in front of a simple dual-port BRAM (port A write, port B read).
// Contention policy selected by BRAM_ARB_RR_EN (round-robin) or fixed priority when undefined.
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clka,
  input  logic                  rst,

  input  logic                  m0_valid,
  output logic                  m0_ready,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [BE_WIDTH-1:0]   m0_we,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,

  input  logic                  m1_valid,
  output logic                  m1_ready,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [BE_WIDTH-1:0]   m1_we,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,

  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic [BE_WIDTH-1:0]   ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_doutb
);

  req_vec_t              valid_masked;
  req_vec_t              grant;
  logic                  granted;
  req_id_t               sel_id;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [BE_WIDTH-1:0]   sel_we;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  rd_fire;

  req_id_t               last_grant_q, last_grant_d;
  logic [RD_LATENCY-1:0] pend_q, pend_d;
  logic [RD_LATENCY-1:0] pend_id_q, pend_id_d;

  // Masking with rst keeps ready low for the whole reset window, not just after the edge.
  assign valid_masked = {m1_valid, m0_valid} & {NUM_REQ{~rst}};

  bram_arb_rr u_arb (
    .valid_i      (valid_masked),
    .last_grant_i (last_grant_q == ReqM1),
    .grant_o      (grant)
  );

  assign m0_ready = grant[0];
  assign m1_ready = grant[1];
  assign granted  = |grant;
  assign sel_id   = onehot_to_id(grant);

  always_comb begin
    sel_addr  = m0_addr;
    sel_we    = m0_we;
    sel_wdata = m0_wdata;
    if (sel_id == ReqM1) begin
      sel_addr  = m1_addr;
      sel_we    = m1_we;
      sel_wdata = m1_wdata;
    end
  end

  // Both RAM ports follow the selected requester so the address buses never float.
  assign ram_addra = sel_addr;
  assign ram_dina  = sel_wdata;
  assign ram_addrb = sel_addr;
  assign ram_wea   = granted ? sel_we : '0;
  assign rd_fire   = granted && (sel_we == '0);

  always_comb begin
    last_grant_d = last_grant_q;
    if (granted) begin
      last_grant_d = sel_id;
    end
  end

  // Response pipeline depth tracks the RAM read latency.
  always_comb begin
    pend_d       = '0;
    pend_id_d    = '0;
    pend_d[0]    = rd_fire;
    pend_id_d[0] = (sel_id == ReqM1);
    for (int i = 1; i < int'(RD_LATENCY); i++) begin
      pend_d[i]    = pend_q[i-1];
      pend_id_d[i] = pend_id_q[i-1];
    end
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      last_grant_q <= ReqM1;
      pend_q       <= '0;
      pend_id_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      pend_q       <= pend_d;
      pend_id_q    <= pend_id_d;
    end
  end

  assign m0_rvalid = pend_q[RD_LATENCY-1] && !pend_id_q[RD_LATENCY-1];
  assign m1_rvalid = pend_q[RD_LATENCY-1] &&  pend_id_q[RD_LATENCY-1];
  assign m0_rdata  = ram_doutb;
  assign m1_rdata  = ram_doutb;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural one-cycle-latency BRAM.
// Contention expectations follow BRAM_ARB_RR_EN when the bench is built with it.
module tb_bram_arbiter;

  localparam int unsigned AW = 11;
`ifdef BRAM_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic          clka = 1'b0;
  logic          rst;
  logic          m0_valid, m0_ready, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [3:0]    m0_we;
  logic [31:0]   m0_wdata, m0_rdata;
  logic          m1_valid, m1_ready, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [3:0]    m1_we;
  logic [31:0]   m1_wdata, m1_rdata;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [31:0]   ram_dina, ram_doutb;
  logic [3:0]    ram_wea;

  logic [31:0]   mem [0:(1<<AW)-1];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clka = ~clka;

  // Read-first BRAM model: port A byte writes, port B registered read.
  always @(posedge clka) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_wea[b]) mem[ram_addra][8*b +: 8] <= ram_dina[8*b +: 8];
    end
    ram_doutb <= mem[ram_addrb];
  end

  bram_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clka      (clka),
    .rst       (rst),
    .m0_valid  (m0_valid),
    .m0_ready  (m0_ready),
    .m0_addr   (m0_addr),
    .m0_we     (m0_we),
    .m0_wdata  (m0_wdata),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_valid  (m1_valid),
    .m1_ready  (m1_ready),
    .m1_addr   (m1_addr),
    .m1_we     (m1_we),
    .m1_wdata  (m1_wdata),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .ram_addra (ram_addra),
    .ram_dina  (ram_dina),
    .ram_wea   (ram_wea),
    .ram_addrb (ram_addrb),
    .ram_doutb (ram_doutb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic idle_inputs();
    m0_valid = 1'b0; m0_addr = '0; m0_we = 4'h0; m0_wdata = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_we = 4'h0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clka);
    #1;
    rst = 1'b0;
  endtask

  bit          lg;
  bit          win, prev;
  logic [31:0] exp_data;

  initial begin
    // Reset window: ready must stay low even with requests present.
    idle_inputs();
    rst = 1'b1;
    m0_valid = 1'b1; m0_we = 4'hF;
    m1_valid = 1'b1; m1_we = 4'hF;
    #2;
    check("rst_m0_ready", m0_ready, 0);
    check("rst_m1_ready", m1_ready, 0);
    check("rst_wea", ram_wea, 0);
    tick();
    check("rst_m0_rvalid", m0_rvalid, 0);
    check("rst_m1_rvalid", m1_rvalid, 0);
    idle_inputs();
    rst = 1'b0;

    // Full write then readback on m0.
    m0_valid = 1'b1; m0_we = 4'hF; m0_addr = 11'h010; m0_wdata = 32'hDEADBEEF;
    #1;
    check("wr_m0_ready", m0_ready, 1);
    check("wr_wea", ram_wea, 4'hF);
    check("wr_addra", ram_addra, 32'h010);
    check("wr_dina", ram_dina, 32'hDEADBEEF);
    tick();
    m0_we = 4'h0;
    #1;
    check("rd_m0_ready", m0_ready, 1);
    check("rd_addrb", ram_addrb, 32'h010);
    check("rd_wea_zero", ram_wea, 0);
    check("wr_no_resp", m0_rvalid, 0);
    tick();
    m0_valid = 1'b0;
    #1;
    check("rd_m0_rvalid", m0_rvalid, 1);
    check("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    check("rd_m1_rvalid", m1_rvalid, 0);
    tick();
    check("rd_rvalid_drop", m0_rvalid, 0);

    // Byte-lane write merge at 0x020.
    m0_valid = 1'b1; m0_we = 4'hF; m0_addr = 11'h020; m0_wdata = 32'h11223344;
    tick();
    m0_we = 4'b0100; m0_wdata = 32'h00AB0000;
    #1;
    check("bw_wea", ram_wea, 4'b0100);
    tick();
    m0_we = 4'h0;
    tick();
    m0_valid = 1'b0;
    #1;
    check("bw_rvalid", m0_rvalid, 1);
    check("bw_rdata", m0_rdata, 32'h11AB3344);
    tick();

    // Six cycles of contending reads, starting from reset arbitration state.
    do_reset();
    m0_valid = 1'b1; m0_addr = 11'h010;
    m1_valid = 1'b1; m1_addr = 11'h020;
    lg = 1'b1;
    prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      win = RrEn ? ~lg : 1'b0;
      check($sformatf("ct_m0_ready_%0d", i), m0_ready, !win);
      check($sformatf("ct_m1_ready_%0d", i), m1_ready, win);
      if (i > 0) begin
        exp_data = prev ? 32'h11AB3344 : 32'hDEADBEEF;
        check($sformatf("ct_m0_rvalid_%0d", i), m0_rvalid, !prev);
        check($sformatf("ct_m1_rvalid_%0d", i), m1_rvalid, prev);
        check($sformatf("ct_rdata_%0d", i), prev ? m1_rdata : m0_rdata, exp_data);
      end
      lg = win;
      prev = win;
      tick();
    end
    idle_inputs();
    #1;
    check("ct_last_m0_rvalid", m0_rvalid, !prev);
    check("ct_last_m1_rvalid", m1_rvalid, prev);
    tick();

    // Reset lands on the edge that would have returned m1's read.
    do_reset();
    m1_valid = 1'b1; m1_addr = 11'h020;
    #1;
    check("rr_m1_ready", m1_ready, 1);
    #7;
    rst = 1'b1;
    @(posedge clka);
    #1;
    check("rr_m1_rvalid", m1_rvalid, 0);
    check("rr_m0_rvalid", m0_rvalid, 0);
    check("rr_m1_ready", m1_ready, 0);
    check("rr_wea", ram_wea, 0);
    tick();
    m1_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rr_after_rvalid_a", m1_rvalid, 0);
    tick();
    check("rr_after_rvalid_b", m1_rvalid, 0);

    // Lone m1 streaming four reads straight out of reset.
    do_reset();
    m1_valid = 1'b1; m1_addr = 11'h020;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("s1_m1_ready_%0d", i), m1_ready, 1);
      check($sformatf("s1_m0_ready_%0d", i), m0_ready, 0);
      check($sformatf("s1_m1_rvalid_%0d", i), m1_rvalid, i > 0);
      if (i > 0) check($sformatf("s1_rdata_%0d", i), m1_rdata, 32'h11AB3344);
      tick();
    end
    m1_valid = 1'b0;
    #1;
    check("s1_last_rvalid", m1_rvalid, 1);
    check("s1_last_rdata", m1_rdata, 32'h11AB3344);
    check("s1_m0_rvalid", m0_rvalid, 0);
    tick();
    check("s1_idle_rvalid", m1_rvalid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
